// File: rtl/hood_pkg.sv
// Shared definitions for the range-hood mode controller and the state indicator.
package hood_pkg;

  // 3-bit hood state encoding, shared with power_state_indicator
  localparam logic [2:0] HOOD_OFF             = 3'd0;
  localparam logic [2:0] HOOD_STANDBY         = 3'd1;
  localparam logic [2:0] HOOD_MODE_SELECT     = 3'd2;
  localparam logic [2:0] HOOD_FIRST_LEVEL     = 3'd3;
  localparam logic [2:0] HOOD_SECOND_LEVEL    = 3'd4;
  localparam logic [2:0] HOOD_THIRD_LEVEL     = 3'd5;
  localparam logic [2:0] HOOD_SELF_CLEAN      = 3'd6;
  localparam logic [2:0] HOOD_WAIT_TO_STANDBY = 3'd7;

  typedef enum logic [2:0] {
    ST_OFF         = HOOD_OFF,
    ST_STANDBY     = HOOD_STANDBY,
    ST_MODE_SELECT = HOOD_MODE_SELECT,
    ST_FIRST       = HOOD_FIRST_LEVEL,
    ST_SECOND      = HOOD_SECOND_LEVEL,
    ST_THIRD       = HOOD_THIRD_LEVEL,
    ST_CLEAN       = HOOD_SELF_CLEAN,
    ST_WAIT        = HOOD_WAIT_TO_STANDBY
  } hood_state_e;

  // Default phase durations in seconds
  localparam int unsigned HURRICANE_SEC_DEF = 60;
  localparam int unsigned RETURN_SEC_DEF    = 60;
  localparam int unsigned CLEAN_SEC_DEF     = 180;

  // States whose duration is governed by the countdown
  function automatic logic is_timed(hood_state_e s);
    return (s == ST_THIRD) || (s == ST_WAIT) || (s == ST_CLEAN);
  endfunction

endpackage

// File: rtl/hood_mode_fsm_countdown_timer.sv
// Seconds countdown: loads on phase entry, decrements on each 1 Hz tick,
// and flags expiry combinationally so the FSM can leave on the same edge.
module countdown_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         expire
);

  logic [W-1:0] count_q;

  // Counter update: clear beats load, load beats (drops) a coincident tick, never wraps
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (tick && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign count  = count_q;
  assign expire = tick && (count_q == W'(1));

endmodule

// File: rtl/hood_mode_fsm.sv
// Master mode controller for the range hood: button pulses and a 1 Hz tick
// drive the 3-bit hood state plus the hurricane / return / self-clean timers.
module hood_mode_fsm
  import hood_pkg::*;
#(
  parameter int unsigned HURRICANE_SEC = HURRICANE_SEC_DEF,
  parameter int unsigned RETURN_SEC    = RETURN_SEC_DEF,
  parameter int unsigned CLEAN_SEC     = CLEAN_SEC_DEF,
  parameter int unsigned COUNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_1hz,
  input  logic               power_btn,
  input  logic               menu_btn,
  input  logic               level1_btn,
  input  logic               level2_btn,
  input  logic               level3_btn,
  input  logic               clean_btn,
  output logic [2:0]         state,
  output logic [COUNT_W-1:0] countdown,
  output logic               hurricane_used
);

  hood_state_e        state_q, state_d;
  logic               hurricane_q;
  logic               load, clr, expire;
  logic [COUNT_W-1:0] load_val;
  logic [COUNT_W-1:0] count;

  // Next-state selection: power first, then menu/level1/level2/level3/clean, expiry last
  always_comb begin
    state_d = state_q;
    if ((state_q != ST_OFF) && power_btn) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (power_btn) state_d = ST_STANDBY;
        end
        ST_STANDBY: begin
          if (menu_btn) state_d = ST_MODE_SELECT;
        end
        ST_MODE_SELECT: begin
          if (menu_btn)                        state_d = ST_STANDBY;
          else if (level1_btn)                 state_d = ST_FIRST;
          else if (level2_btn)                 state_d = ST_SECOND;
          else if (level3_btn && !hurricane_q) state_d = ST_THIRD;
          else if (clean_btn)                  state_d = ST_CLEAN;
        end
        ST_FIRST, ST_SECOND: begin
          if (menu_btn)                        state_d = ST_STANDBY;
          else if (level1_btn)                 state_d = ST_FIRST;
          else if (level2_btn)                 state_d = ST_SECOND;
          else if (level3_btn && !hurricane_q) state_d = ST_THIRD;
        end
        ST_THIRD: begin
          if (menu_btn)    state_d = ST_WAIT;
          else if (expire) state_d = ST_SECOND;
        end
        ST_WAIT: begin
          if (level1_btn)      state_d = ST_FIRST;
          else if (level2_btn) state_d = ST_SECOND;
          else if (expire)     state_d = ST_STANDBY;
        end
        ST_CLEAN: begin
          if (expire) state_d = ST_STANDBY;
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // Load-value mux: a timed phase loads its duration only when it is newly entered;
  // any untimed destination holds the countdown at zero
  always_comb begin
    load     = 1'b0;
    load_val = '0;
    clr      = !is_timed(state_d);
    if (state_d != state_q) begin
      case (state_d)
        ST_THIRD: begin
          load     = 1'b1;
          load_val = COUNT_W'(HURRICANE_SEC);
        end
        ST_WAIT: begin
          load     = 1'b1;
          load_val = COUNT_W'(RETURN_SEC);
        end
        ST_CLEAN: begin
          load     = 1'b1;
          load_val = COUNT_W'(CLEAN_SEC);
        end
        default: begin
          load     = 1'b0;
          load_val = '0;
        end
      endcase
    end
  end

  // State and hurricane-lockout registers; the lockout lives for one power cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_OFF;
      hurricane_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == ST_OFF) begin
        hurricane_q <= 1'b0;
      end else if ((state_d == ST_THIRD) && (state_q != ST_THIRD)) begin
        hurricane_q <= 1'b1;
      end
    end
  end

  countdown_timer #(
    .W(COUNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .load_val(load_val),
    .tick    (tick_1hz),
    .clr     (clr),
    .count   (count),
    .expire  (expire)
  );

  assign state          = state_q;
  assign countdown      = count;
  assign hurricane_used = hurricane_q;

endmodule

// File: tb/tb_hood_mode_fsm.sv
// Bench for hood_mode_fsm: directed walk through the hood's modes followed by
// random button/tick/reset traffic, all checked against a behavioural model.
module tb_hood_mode_fsm;

  localparam int H_SEC = 3;
  localparam int R_SEC = 2;
  localparam int C_SEC = 4;

  // Button vector bits: 0 power, 1 menu, 2 level1, 3 level2, 4 level3, 5 clean
  localparam logic [5:0] B_NONE  = 6'b000000;
  localparam logic [5:0] B_PWR   = 6'b000001;
  localparam logic [5:0] B_MENU  = 6'b000010;
  localparam logic [5:0] B_L1    = 6'b000100;
  localparam logic [5:0] B_L2    = 6'b001000;
  localparam logic [5:0] B_L3    = 6'b010000;
  localparam logic [5:0] B_CLEAN = 6'b100000;

  logic       clk = 1'b0;
  logic       rst_n, tick_1hz;
  logic       power_btn, menu_btn, level1_btn, level2_btn, level3_btn, clean_btn;
  logic [2:0] state;
  logic [7:0] countdown;
  logic       hurricane_used;

  int checks   = 0;
  int failures = 0;

  // Reference model: hood mode number, seconds remaining, lockout flag
  int m_mode = 0;
  int m_secs = 0;
  int m_lock = 0;

  always #5 clk = ~clk;

  hood_mode_fsm #(
    .HURRICANE_SEC(H_SEC),
    .RETURN_SEC   (R_SEC),
    .CLEAN_SEC    (C_SEC),
    .COUNT_W      (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick_1hz      (tick_1hz),
    .power_btn     (power_btn),
    .menu_btn      (menu_btn),
    .level1_btn    (level1_btn),
    .level2_btn    (level2_btn),
    .level3_btn    (level3_btn),
    .clean_btn     (clean_btn),
    .state         (state),
    .countdown     (countdown),
    .hurricane_used(hurricane_used)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int phase_length(input int mode);
    if (mode == 5) return H_SEC;
    if (mode == 7) return R_SEC;
    if (mode == 6) return C_SEC;
    return 0;
  endfunction

  // One clock of hood behaviour, described from the user's point of view:
  // which button (if any) is honoured, otherwise whether the running phase ends.
  task automatic model_step(input logic [5:0] b, input logic t, input logic r);
    int target;
    bit pwr, menu, l1, l2, l3, cln, ends_now;
    if (!r) begin
      m_mode = 0; m_secs = 0; m_lock = 0;
      return;
    end
    {cln, l3, l2, l1, menu, pwr} = b;
    target   = -1;
    ends_now = t && (m_secs == 1);
    if (pwr) begin
      target = (m_mode == 0) ? 1 : 0;
    end else if (m_mode == 1 && menu) begin
      target = 2;
    end else if (m_mode == 2 || m_mode == 3 || m_mode == 4) begin
      if (menu)                 target = 1;
      else if (l1)              target = 3;
      else if (l2)              target = 4;
      else if (l3 && !m_lock)   target = 5;
      else if (cln && m_mode == 2) target = 6;
    end else if (m_mode == 5 && menu) begin
      target = 7;
    end else if (m_mode == 7 && (l1 || l2)) begin
      target = l1 ? 3 : 4;
    end
    if (target < 0 && ends_now) target = (m_mode == 5) ? 4 : 1;

    if (target < 0 || target == m_mode) begin
      if (t && m_secs > 0) m_secs = m_secs - 1;
      if (target == m_mode && phase_length(m_mode) == 0) m_secs = 0;
    end else begin
      m_mode = target;
      m_secs = phase_length(target);
      if (target == 5) m_lock = 1;
      if (target == 0) m_lock = 0;
    end
  endtask

  task automatic cyc(input logic [5:0] b, input logic t, input logic r);
    {clean_btn, level3_btn, level2_btn, level1_btn, menu_btn, power_btn} = b;
    tick_1hz = t;
    rst_n    = r;
    @(posedge clk);
    model_step(b, t, r);
    #1;
    check_val("state", 32'(state), 32'(m_mode));
    check_val("countdown", 32'(countdown), 32'(m_secs));
    check_val("hurricane_used", 32'(hurricane_used), 32'(m_lock));
    {clean_btn, level3_btn, level2_btn, level1_btn, menu_btn, power_btn} = B_NONE;
    tick_1hz = 1'b0;
    rst_n    = 1'b1;
  endtask

  initial begin
    logic [5:0] b;
    logic       t, r;
    {clean_btn, level3_btn, level2_btn, level1_btn, menu_btn, power_btn} = B_NONE;
    tick_1hz = 1'b0;
    rst_n    = 1'b0;

    // Reset state
    cyc(B_NONE, 1'b0, 1'b0);
    cyc(B_NONE, 1'b0, 1'b0);
    check_val("reset_state", 32'(state), 32'd0);
    check_val("reset_countdown", 32'(countdown), 32'd0);
    check_val("reset_hu", 32'(hurricane_used), 32'd0);

    // Power-up path
    cyc(B_PWR, 1'b0, 1'b1);  check_val("pwr_standby", 32'(state), 32'd1);
    cyc(B_MENU, 1'b0, 1'b1); check_val("menu_select", 32'(state), 32'd2);
    cyc(B_L2, 1'b0, 1'b1);   check_val("level2", 32'(state), 32'd4);

    // Hurricane expiry
    cyc(B_MENU, 1'b0, 1'b1);
    cyc(B_MENU, 1'b0, 1'b1);
    cyc(B_L3, 1'b0, 1'b1);   check_val("hurr_load", 32'(countdown), 32'd3);
    cyc(B_NONE, 1'b1, 1'b1); check_val("hurr_2", 32'(countdown), 32'd2);
    cyc(B_NONE, 1'b1, 1'b1); check_val("hurr_1", 32'(countdown), 32'd1);
    cyc(B_NONE, 1'b1, 1'b1); check_val("hurr_expire", 32'(state), 32'd4);
    check_val("hurr_used", 32'(hurricane_used), 32'd1);

    // Hurricane lockout, then cleared by a power cycle
    cyc(B_L3, 1'b0, 1'b1);   check_val("lockout", 32'(state), 32'd4);
    cyc(B_PWR, 1'b0, 1'b1);
    cyc(B_PWR, 1'b0, 1'b1);
    cyc(B_MENU, 1'b0, 1'b1);
    cyc(B_L3, 1'b0, 1'b1);   check_val("relock_third", 32'(state), 32'd5);

    // Return delay: expire, then cancel with level1
    cyc(B_MENU, 1'b0, 1'b1); check_val("wait_load", 32'(countdown), 32'd2);
    cyc(B_NONE, 1'b1, 1'b1);
    cyc(B_NONE, 1'b1, 1'b1); check_val("wait_expire", 32'(state), 32'd1);
    cyc(B_PWR, 1'b0, 1'b1);
    cyc(B_PWR, 1'b0, 1'b1);
    cyc(B_MENU, 1'b0, 1'b1);
    cyc(B_L3, 1'b0, 1'b1);
    cyc(B_MENU, 1'b0, 1'b1);
    cyc(B_NONE, 1'b1, 1'b1);
    cyc(B_L1, 1'b0, 1'b1);   check_val("wait_cancel", 32'(state), 32'd3);
    check_val("wait_cancel_cd", 32'(countdown), 32'd0);

    // Self-clean
    cyc(B_MENU, 1'b0, 1'b1);
    cyc(B_MENU, 1'b0, 1'b1);
    cyc(B_CLEAN, 1'b0, 1'b1); check_val("clean_load", 32'(countdown), 32'd4);
    cyc(B_L1, 1'b0, 1'b1);    check_val("clean_ignore", 32'(state), 32'd6);
    for (int i = 0; i < 4; i++) cyc(B_NONE, 1'b1, 1'b1);
    check_val("clean_expire", 32'(state), 32'd1);

    // Collisions
    cyc(B_PWR | B_MENU, 1'b0, 1'b1); check_val("pwr_beats_menu", 32'(state), 32'd0);
    cyc(B_PWR, 1'b0, 1'b1);
    cyc(B_MENU, 1'b0, 1'b1);
    cyc(B_L3, 1'b1, 1'b1);   check_val("load_beats_tick", 32'(countdown), 32'd3);
    cyc(B_MENU, 1'b0, 1'b1);
    cyc(B_L1, 1'b0, 1'b1);
    cyc(B_MENU, 1'b0, 1'b1);
    cyc(B_MENU, 1'b0, 1'b1);
    cyc(B_CLEAN, 1'b0, 1'b1);
    cyc(B_NONE, 1'b1, 1'b1);
    cyc(B_NONE, 1'b0, 1'b0);
    check_val("rst_mid_clean", 32'(state), 32'd0);
    check_val("rst_mid_clean_cd", 32'(countdown), 32'd0);
    check_val("rst_mid_clean_hu", 32'(hurricane_used), 32'd0);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      b = B_NONE;
      if ($urandom_range(0, 29) == 0) b[0] = 1'b1;
      for (int k = 1; k < 6; k++) if ($urandom_range(0, 9) == 0) b[k] = 1'b1;
      t = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 399) != 0);
      cyc(b, t, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hood_mode_fsm.md
# hood_mode_fsm

Master mode controller for the range hood. It turns single-cycle button pulses and a 1 Hz tick into the 3-bit hood state that `power_state_indicator` decodes. It also owns the three timed phases: hurricane (third level), the return-to-standby delay, and self-clean. It sits between the button debouncers and the indicator/display logic.

## Interface
- `HURRICANE_SEC`, 60: THIRD_LEVEL duration in seconds, 1..2^COUNT_W-1.
- `RETURN_SEC`, 60: WAIT_TO_STANDBY duration in seconds, 1..2^COUNT_W-1.
- `CLEAN_SEC`, 180: SELF_CLEAN duration in seconds, 1..2^COUNT_W-1.
- `COUNT_W`, 8: countdown register width.

- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `tick_1hz`  in  1  one-cycle pulse, once per second.
- `power_btn`  in  1  debounced one-cycle pulse.
- `menu_btn`  in  1  debounced one-cycle pulse.
- `level1_btn`, `level2_btn`, `level3_btn`  in  1 each  debounced one-cycle pulses.
- `clean_btn`  in  1  debounced one-cycle pulse.
- `state`  out  3  registered hood state: OFF=0, STANDBY=1, MODE_SELECT=2, FIRST_LEVEL=3, SECOND_LEVEL=4, THIRD_LEVEL=5, SELF_CLEAN=6, WAIT_TO_STANDBY=7.
- `countdown`  out  COUNT_W  seconds remaining. It is 0 outside THIRD_LEVEL, WAIT_TO_STANDBY and SELF_CLEAN.
- `hurricane_used`  out  1  set once THIRD_LEVEL has been entered in the current power cycle.

## Operation
- Reset values: `state`=OFF, `countdown`=0, `hurricane_used`=0.
- In any state except OFF, `power_btn` has top priority and sends the FSM to OFF.
- On entry to OFF, `hurricane_used` is cleared and `countdown` is cleared.
- Other simultaneous buttons are resolved in this priority order: menu, level1, level2, level3, clean.
- OFF: `power_btn` goes to STANDBY. All other buttons are ignored.
- STANDBY: `menu_btn` goes to MODE_SELECT.
- MODE_SELECT:
  - level1 goes to FIRST_LEVEL; level2 goes to SECOND_LEVEL.
  - level3 goes to THIRD_LEVEL only if `hurricane_used`=0; otherwise it is ignored.
  - clean goes to SELF_CLEAN.
  - menu goes to STANDBY.
- FIRST_LEVEL / SECOND_LEVEL:
  - level1 and level2 switch between these two states directly.
  - level3 follows the same rule as in MODE_SELECT.
  - menu goes to STANDBY immediately.
- THIRD_LEVEL:
  - Entry loads `countdown`=HURRICANE_SEC and sets `hurricane_used`.
  - When the countdown expires, the FSM goes to SECOND_LEVEL.
  - menu goes to WAIT_TO_STANDBY.
  - level1/level2/level3/clean are ignored.
- WAIT_TO_STANDBY:
  - Entry loads RETURN_SEC; expiry goes to STANDBY.
  - level1/level2 return to the selected level and cancel the countdown to 0.
  - The other buttons are ignored.
- SELF_CLEAN: entry loads CLEAN_SEC; expiry goes to STANDBY. All buttons except power are ignored.
- Countdown rule:
  - Each `tick_1hz` decrements `countdown`.
  - A tick while `countdown`==1 is expiry: the state transition and `countdown`←0 (or the next state's load value) happen on the same edge.
  - `countdown` never wraps below 0.
- Loads on entry take precedence over a coincident tick; the tick is dropped.
- A button accepted in the same cycle as expiry wins over the expiry. The expiry is then discarded.

## Timing
- Latency is one cycle: a pulse sampled at edge N appears in `state`/`countdown` after edge N.
- All outputs are registered. There is no combinational path from the inputs.
- Buttons asserted for more than one cycle act as repeated pulses. Debouncers are required to deliver single pulses.
- Reset is sampled only at `clk` edges and overrides all inputs, including during a countdown.
- After reset release, the FSM sits in OFF with `hurricane_used`=0.

## Structure
- A shared package `hood_pkg` holds:
  - the 3-bit state localparams (the encoding listed above), used by this block and by `power_state_indicator`;
  - the default second constants.
- One sub-module, `countdown_timer`:
  - inputs: `load`, `load_val`, `tick`, `clr`;
  - outputs: `count`, one-cycle `expire`.
- The FSM is a single registered next-state process plus a load-value mux that feeds `countdown_timer`.

## Test plan
Benches use HURRICANE_SEC=3, RETURN_SEC=2, CLEAN_SEC=4.
- Power-up path: reset, power, menu, level2 → state goes 0→1→2→4, one cycle after each pulse; `countdown` stays 0.
- Hurricane expiry: from MODE_SELECT press level3, then give 3 ticks → state=5 with `countdown` 3,2,1, then state=4 with `countdown`=0 on the third tick; `hurricane_used`=1.
- Hurricane lockout: with the previous step's `hurricane_used`=1, press level3 in SECOND_LEVEL → state stays 4. Then power, power, menu, level3 → state=5, because the power cycle cleared the flag.
- Return delay: in THIRD_LEVEL press menu → state=7, `countdown`=2. Two ticks → state=1. Repeat, and press level1 after one tick → state=3, `countdown`=0.
- Self-clean: from MODE_SELECT press clean → state=6, `countdown`=4. Pulse level1 → no change. Four ticks → state=1.
- Collisions:
  - power with menu in STANDBY → OFF.
  - tick in the cycle a load happens → `countdown` equals the full load value.
  - `rst_n`=0 in mid-SELF_CLEAN → state=0, `countdown`=0, `hurricane_used`=0 after the next edge.
